div_share_arbiter: RTL and testbench

- Shares one fractional-quotient datapath, out = (a<<8)/b, between several pixel-pipeline requesters.
- Typical requesters are the R, G and B normalisation lanes that divide by atmospheric light A during haze removal.
- Arbitrates with a round-robin pointer, registers operands, computes, and holds the tagged result under a valid/ready handshake.
- Sits between the per-channel lanes and the downstream transmission/recovery stage.

---
 rtl/div_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_div_share_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin shared (a<<8)/b datapath for several requesters
// Grants one requester in IDLE, divides in CALC, holds the tagged result in HOLD.
module div_share_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [15:0]            res_quot,
  output logic [ID_W-1:0]        res_id,
  output logic                   res_divzero,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            res_valid_q, res_valid_d;
  logic [15:0]     res_quot_q, res_quot_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic            res_divzero_q, res_divzero_d;

  logic            gnt_any;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] scan_idx;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  // Scan from the farthest slot back to rr_ptr so the nearest valid requester wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = wrap_add(rr_ptr_q, k);
      if (req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == IDLE) && gnt_any) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    res_valid_d   = res_valid_q;
    res_quot_d    = res_quot_q;
    res_id_d      = res_id_q;
    res_divzero_d = res_divzero_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          a_d      = req_a[8*gnt_id +: 8];
          b_d      = req_b[8*gnt_id +: 8];
          id_d     = gnt_id;
          rr_ptr_d = wrap_add(gnt_id, 1);
          state_d  = CALC;
        end
      end
      CALC: begin
        if (b_q != 8'h00) begin
          res_quot_d    = {a_q, 8'h00} / {8'h00, b_q};
          res_divzero_d = 1'b0;
        end else begin
          res_quot_d    = 16'hFFFF;
          res_divzero_d = 1'b1;
        end
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= '0;
      res_valid_q   <= 1'b0;
      res_quot_q    <= '0;
      res_id_q      <= '0;
      res_divzero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      a_q           <= a_d;
      b_q           <= b_d;
      id_q          <= id_d;
      res_valid_q   <= res_valid_d;
      res_quot_q    <= res_quot_d;
      res_id_q      <= res_id_d;
      res_divzero_q <= res_divzero_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_quot    = res_quot_q;
  assign res_id      = res_id_q;
  assign res_divzero = res_divzero_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - directed self-checking bench for div_share_arbiter
module tb_div_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [23:0] req_a;
  logic [23:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_quot;
  logic [1:0]  res_id;
  logic        res_divzero;
  logic        busy;

  int total = 0;
  int bad   = 0;

  div_share_arbiter #(.NUM_REQ(3), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_quot(res_quot), .res_id(res_id), .res_divzero(res_divzero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 3'b111;
    rst = 1'b1;
    tick();
    #1;
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rst_req_ready got=%b exp=000", req_ready); end
    tick();
    req_valid = 3'b000;
    rst = 1'b0;
    #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    total++; if (res_quot !== 16'h0000) begin bad++; $display("FAIL rst_res_quot got=%h exp=0000", res_quot); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL rst_res_id got=%0d exp=0", res_id); end
    total++; if (res_divzero !== 1'b0) begin bad++; $display("FAIL rst_divzero got=%b exp=0", res_divzero); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic_frac();
    do_reset();
    res_ready = 1'b1;
    set_op(0, 8'd128, 8'd255);
    req_valid = 3'b001;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL frac_grant got=%b exp=001", req_ready); end
    tick();
    req_valid = 3'b000;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL frac_early_valid got=%b exp=0", res_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL frac_busy got=%b exp=1", busy); end
    tick();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL frac_valid got=%b exp=1", res_valid); end
    total++; if (res_quot !== 16'h0080) begin bad++; $display("FAIL frac_quot got=%h exp=0080", res_quot); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL frac_id got=%0d exp=0", res_id); end
    total++; if (res_divzero !== 1'b0) begin bad++; $display("FAIL frac_divzero got=%b exp=0", res_divzero); end
    tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL frac_release got=%b exp=0", res_valid); end
  endtask

  task automatic test_basic_int();
    set_op(0, 8'd200, 8'd100);
    req_valid = 3'b001;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL int_grant got=%b exp=001", req_ready); end
    tick();
    req_valid = 3'b000;
    tick();
    total++; if (res_quot !== 16'd512) begin bad++; $display("FAIL int_quot got=%0d exp=512", res_quot); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_rdy [4];
    logic [15:0] exp_q [4];
    exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_q   = '{16'd64, 16'd128, 16'd192, 16'd64};
    set_op(0, 8'd10, 8'd40);
    set_op(1, 8'd20, 8'd40);
    set_op(2, 8'd30, 8'd40);
    res_ready = 1'b1;
    req_valid = 3'b111;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      #1;
      total++; if (req_ready !== exp_rdy[g]) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", g, req_ready, exp_rdy[g]); end
      tick();
      tick();
      total++; if (res_quot !== exp_q[g]) begin bad++; $display("FAIL rr_quot%0d got=%0d exp=%0d", g, res_quot, exp_q[g]); end
      tick();
    end
    req_valid = 3'b000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_op(0, 8'd255, 8'd1);
    set_op(1, 8'd1, 8'd1);
    set_op(2, 8'd1, 8'd1);
    req_valid = 3'b001;
    res_ready = 1'b1;
    tick();
    req_valid = 3'b111;
    res_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%b exp=1", i, res_valid); end
      total++; if (res_quot !== 16'd65280) begin bad++; $display("FAIL bp_quot%0d got=%0d exp=65280", i, res_quot); end
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL bp_ready%0d got=%b exp=000", i, req_ready); end
      tick();
    end
    res_ready = 1'b1;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_still_valid got=%b exp=1", res_valid); end
    tick();
    #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_fall got=%b exp=0", res_valid); end
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL bp_next_grant got=%b exp=010", req_ready); end
    tick();
    req_valid = 3'b000;
    tick();
    total++; if (res_quot !== 16'd256 || res_id !== 2'd1) begin bad++; $display("FAIL bp_next_res got=%0d/%0d exp=256/1", res_quot, res_id); end
    tick();
  endtask

  task automatic test_divzero();
    do_reset();
    res_ready = 1'b1;
    set_op(2, 8'd77, 8'd0);
    req_valid = 3'b100;
    #1;
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL dz_grant got=%b exp=100", req_ready); end
    tick();
    req_valid = 3'b000;
    tick();
    total++; if (res_quot !== 16'hFFFF) begin bad++; $display("FAIL dz_quot got=%h exp=ffff", res_quot); end
    total++; if (res_divzero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", res_divzero); end
    total++; if (res_id !== 2'd2) begin bad++; $display("FAIL dz_id got=%0d exp=2", res_id); end
    tick();
    set_op(0, 8'd1, 8'd2);
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    tick();
    total++; if (res_quot !== 16'd128) begin bad++; $display("FAIL dz_next_quot got=%0d exp=128", res_quot); end
    total++; if (res_divzero !== 1'b0) begin bad++; $display("FAIL dz_next_flag got=%b exp=0", res_divzero); end
    tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    res_ready = 1'b1;
    set_op(1, 8'd5, 8'd5);
    set_op(2, 8'd9, 8'd3);
    // Grant requester 1 so rr_ptr sits at 2 before the reset.
    req_valid = 3'b010;
    tick();
    req_valid = 3'b000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL calc_rst_valid got=%b exp=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL calc_rst_busy got=%b exp=0", busy); end
    req_valid = 3'b110;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL calc_rst_grant got=%b exp=010", req_ready); end
    tick();
    req_valid = 3'b000;
    tick();
    total++; if (res_id !== 2'd1 || res_quot !== 16'd256) begin bad++; $display("FAIL calc_rst_res got=%0d/%0d exp=1/256", res_id, res_quot); end
    tick();
    res_ready = 1'b0;
    req_valid = 3'b010;
    tick();
    req_valid = 3'b000;
    tick();
    tick();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL hold_pre_valid got=%b exp=1", res_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL hold_rst_valid got=%b exp=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_rst_busy got=%b exp=0", busy); end
    req_valid = 3'b110;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL hold_rst_grant got=%b exp=010", req_ready); end
    req_valid = 3'b000;
    res_ready = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    logic [2:0] exp_rdy [4];
    logic [1:0] exp_id [4];
    exp_rdy = '{3'b001, 3'b100, 3'b001, 3'b100};
    exp_id  = '{2'd0, 2'd2, 2'd0, 2'd2};
    do_reset();
    res_ready = 1'b1;
    set_op(0, 8'd1, 8'd1);
    set_op(2, 8'd2, 8'd1);
    req_valid = 3'b101;
    for (int g = 0; g < 4; g++) begin
      #1;
      total++; if (req_ready !== exp_rdy[g]) begin bad++; $display("FAIL fair_grant%0d got=%b exp=%b", g, req_ready, exp_rdy[g]); end
      tick();
      tick();
      total++; if (res_id !== exp_id[g]) begin bad++; $display("FAIL fair_id%0d got=%0d exp=%0d", g, res_id, exp_id[g]); end
      tick();
    end
    req_valid = 3'b000;
    tick();
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 3'b000;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic_frac();
    test_basic_int();
    test_round_robin();
    test_back_pressure();
    test_divzero();
    test_reset_midop();
    test_fairness();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
